cpu_sram_arbiter: RTL and testbench

- Shares one SRAM-like memory port between the CPU instruction-side and data-side requesters.
- Sits between the inst_sram/data_sram request interfaces of the five-stage pipeline and the single downstream memory (or AXI bridge).
- Uses round-robin arbitration with one outstanding transaction in total.
- Latches the winning request, issues it downstream, and routes the response back to the owner.

---
 rtl/cpu_sram_arbiter_pkg.sv | 24 ++
 rtl/cpu_sram_arbiter_if.sv | 37 +++
 rtl/cpu_sram_arbiter_rr_arb2.sv | 48 ++++
 rtl/cpu_sram_arbiter.sv | 122 ++++++++++++
 tb/tb_cpu_sram_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_sram_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cpu_sram_arbiter_pkg
// Shared types for the CPU SRAM-port arbiter: FSM state encodings, owner
// codes and default bus widths.
// -----------------------------------------------------------------------------
package cpu_sram_arbiter_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    // Arbiter transaction FSM
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    // Which requester owns the outstanding transaction
    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_t;

endpackage

// File: rtl/cpu_sram_arbiter_if.sv
// -----------------------------------------------------------------------------
// cpu_sram_arbiter_if
// SRAM-like request/response bus as used by the pipeline and the downstream
// memory. The master issues req/wr/wstrb/addr/wdata and receives
// addr_ok/data_ok/rdata from the slave.
//   master   : requester view (drives the request)
//   slave    : responder view (drives the handshake/response)
//   slave_rd : responder view of a read-only requester (instruction side)
// -----------------------------------------------------------------------------
interface cpu_sram_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic                  req;
    logic                  wr;
    logic [DATA_W/8-1:0]   wstrb;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  addr_ok;
    logic                  data_ok;
    logic [DATA_W-1:0]     rdata;

    modport master (
        output req, wr, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );

    modport slave_rd (
        input  req, addr,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/cpu_sram_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin grant between the instruction and data requesters.
// A lone requester always wins; on a tie the side opposite last_grant wins.
// last_grant only moves when update_i is high and a grant is issued.
//   clk, reset            : clock, synchronous active-high reset
//   req_inst_i/req_data_i : request inputs
//   update_i              : commit this cycle's grant into last_grant
//   gnt_inst_o/gnt_data_o : combinational one-hot (or zero) grant
// -----------------------------------------------------------------------------
module rr_arb2
    import cpu_sram_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req_inst_i,
    input  logic req_data_i,
    input  logic update_i,
    output logic gnt_inst_o,
    output logic gnt_data_o
);

    owner_t last_q;
    owner_t last_d;

    // Reset to inst so that data wins the very first tie.
    assign gnt_data_o = req_data_i & (~req_inst_i | (last_q == OWN_INST));
    assign gnt_inst_o = req_inst_i & (~req_data_i | (last_q == OWN_DATA));

    always_comb begin
        // NOTE: default assignment first so every path drives last_d and no latch is inferred.
        last_d = last_q;
        if (update_i && gnt_data_o) begin
            last_d = OWN_DATA;
        end else if (update_i && gnt_inst_o) begin
            last_d = OWN_INST;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= OWN_INST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/cpu_sram_arbiter.sv
// -----------------------------------------------------------------------------
// cpu_sram_arbiter
// Shares one SRAM-like downstream port between the CPU instruction and data
// requesters with round-robin arbitration and one outstanding transaction.
// The winning request is latched in IDLE, presented downstream in REQ until
// accepted, and the response is routed back to the owner in WAIT.
//   clk, reset : clock, synchronous active-high reset
//   inst_s     : instruction-side requester (read-only)
//   data_s     : data-side requester (read/write)
//   mem_m      : downstream memory / bridge port
// -----------------------------------------------------------------------------
module cpu_sram_arbiter
    import cpu_sram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_sram_arbiter_if.slave_rd inst_s,
    cpu_sram_arbiter_if.slave    data_s,
    cpu_sram_arbiter_if.master   mem_m
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_t              state_q;
    owner_t              owner_q;
    logic                m_req_q;
    logic                wr_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;

    logic idle;
    logic gnt_inst;
    logic gnt_data;
    logic resp_fire;

    assign idle = (state_q == ST_IDLE);

    // Requests are only considered in IDLE, so grants (and addr_ok) can never
    // appear while a transaction is outstanding.
    rr_arb2 u_rr_arb2 (
        .clk        (clk),
        .reset      (reset),
        .req_inst_i (idle & inst_s.req),
        .req_data_i (idle & data_s.req),
        .update_i   (idle),
        .gnt_inst_o (gnt_inst),
        .gnt_data_o (gnt_data)
    );

    // A response is only meaningful in WAIT; stale pulses elsewhere are dropped.
    assign resp_fire = (state_q == ST_WAIT) & mem_m.data_ok;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_INST;
            m_req_q <= 1'b0;
            wr_q    <= 1'b0;
            wstrb_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            case (state_q)
                ST_IDLE: begin
                    if (gnt_data) begin
                        owner_q <= OWN_DATA;
                        wr_q    <= data_s.wr;
                        wstrb_q <= data_s.wstrb;
                        addr_q  <= data_s.addr;
                        wdata_q <= data_s.wdata;
                        m_req_q <= 1'b1;
                        state_q <= ST_REQ;
                    end else if (gnt_inst) begin
                        owner_q <= OWN_INST;
                        wr_q    <= 1'b0;
                        wstrb_q <= '0;
                        addr_q  <= inst_s.addr;
                        wdata_q <= '0;
                        m_req_q <= 1'b1;
                        state_q <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_m.addr_ok) begin
                        m_req_q <= 1'b0;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_m.data_ok) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    m_req_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Downstream request comes only from the latched fields.
    assign mem_m.req   = m_req_q;
    assign mem_m.wr    = wr_q;
    assign mem_m.wstrb = wstrb_q;
    assign mem_m.addr  = addr_q;
    assign mem_m.wdata = wdata_q;

    // Upstream handshakes; read data is a pass-through qualified by data_ok.
    assign inst_s.addr_ok = gnt_inst;
    assign data_s.addr_ok = gnt_data;
    assign inst_s.data_ok = resp_fire & (owner_q == OWN_INST);
    assign data_s.data_ok = resp_fire & (owner_q == OWN_DATA);
    assign inst_s.rdata   = mem_m.rdata;
    assign data_s.rdata   = mem_m.rdata;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpu_sram_arbiter
// Directed self-checking bench for cpu_sram_arbiter. The bench plays both the
// CPU requesters and the downstream memory. Inputs change on the falling edge
// and outputs are sampled 1 ns later, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_cpu_sram_arbiter;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    cpu_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_bus ();
    cpu_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_bus ();
    cpu_sram_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_bus ();

    cpu_sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .inst_s (inst_bus),
        .data_s (data_bus),
        .mem_m  (mem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (inst_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL reset_i_addr_ok: got %0b want 0", inst_bus.addr_ok); end
        checks++; if (data_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL reset_d_addr_ok: got %0b want 0", data_bus.addr_ok); end
        checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %0b want 0", mem_bus.req); end
        checks++; if (mem_bus.addr !== 32'h0) begin errors++; $display("FAIL reset_m_addr: got %h want 0", mem_bus.addr); end
        checks++; if (mem_bus.wstrb !== 4'h0) begin errors++; $display("FAIL reset_m_wstrb: got %h want 0", mem_bus.wstrb); end
        checks++; if ({inst_bus.data_ok, data_bus.data_ok} !== 2'b00) begin errors++; $display("FAIL reset_data_ok: got %b want 00", {inst_bus.data_ok, data_bus.data_ok}); end
        reset = 1'b0;
    endtask

    task automatic test_inst_read();
        @(negedge clk);
        inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0000;
        #1;
        checks++; if (inst_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL ird_i_addr_ok: got %0b want 1", inst_bus.addr_ok); end
        checks++; if (data_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL ird_d_addr_ok: got %0b want 0", data_bus.addr_ok); end
        @(negedge clk);
        inst_bus.req = 1'b0; inst_bus.addr = 32'h0; mem_bus.addr_ok = 1'b1;
        #1;
        checks++; if (mem_bus.req !== 1'b1) begin errors++; $display("FAIL ird_m_req: got %0b want 1", mem_bus.req); end
        checks++; if (mem_bus.addr !== 32'hBFC0_0000) begin errors++; $display("FAIL ird_m_addr: got %h want bfc00000", mem_bus.addr); end
        checks++; if (mem_bus.wr !== 1'b0) begin errors++; $display("FAIL ird_m_wr: got %0b want 0", mem_bus.wr); end
        @(negedge clk);
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h3C1D_0000;
        #1;
        checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("FAIL ird_m_req_wait: got %0b want 0", mem_bus.req); end
        checks++; if (inst_bus.data_ok !== 1'b1) begin errors++; $display("FAIL ird_i_data_ok: got %0b want 1", inst_bus.data_ok); end
        checks++; if (inst_bus.rdata !== 32'h3C1D_0000) begin errors++; $display("FAIL ird_i_rdata: got %h want 3c1d0000", inst_bus.rdata); end
        checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL ird_d_data_ok: got %0b want 0", data_bus.data_ok); end
        @(negedge clk);
        mem_bus.data_ok = 1'b0;
        #1;
        checks++; if (inst_bus.data_ok !== 1'b0) begin errors++; $display("FAIL ird_i_data_ok_pulse: got %0b want 0", inst_bus.data_ok); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0004;
        data_bus.req = 1'b1; data_bus.wr = 1'b0; data_bus.addr = 32'h8000_0000;
        #1;
        checks++; if (data_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL sim_d_first: got %0b want 1", data_bus.addr_ok); end
        checks++; if (inst_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL sim_i_loses: got %0b want 0", inst_bus.addr_ok); end
        @(negedge clk);
        data_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
        #1;
        checks++; if (mem_bus.addr !== 32'h8000_0000) begin errors++; $display("FAIL sim_m_addr_d: got %h want 80000000", mem_bus.addr); end
        checks++; if (inst_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL sim_i_addr_ok_req: got %0b want 0", inst_bus.addr_ok); end
        @(negedge clk);
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h1111_2222;
        #1;
        checks++; if (data_bus.data_ok !== 1'b1) begin errors++; $display("FAIL sim_d_data_ok: got %0b want 1", data_bus.data_ok); end
        checks++; if (data_bus.rdata !== 32'h1111_2222) begin errors++; $display("FAIL sim_d_rdata: got %h want 11112222", data_bus.rdata); end
        checks++; if (inst_bus.addr_ok !== 1'b0) begin errors++; $display("FAIL sim_no_grant_on_data_ok: got %0b want 0", inst_bus.addr_ok); end
        checks++; if (inst_bus.data_ok !== 1'b0) begin errors++; $display("FAIL sim_i_data_ok_wrong_owner: got %0b want 0", inst_bus.data_ok); end
        @(negedge clk);
        mem_bus.data_ok = 1'b0;
        #1;
        checks++; if (inst_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL sim_i_second: got %0b want 1", inst_bus.addr_ok); end
        @(negedge clk);
        inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
        #1;
        checks++; if (mem_bus.addr !== 32'hBFC0_0004) begin errors++; $display("FAIL sim_m_addr_i: got %h want bfc00004", mem_bus.addr); end
        @(negedge clk);
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h3333_4444;
        #1;
        checks++; if (inst_bus.data_ok !== 1'b1) begin errors++; $display("FAIL sim_i_data_ok: got %0b want 1", inst_bus.data_ok); end
        @(negedge clk);
        mem_bus.data_ok = 1'b0;
    endtask

    task automatic test_data_write();
        @(negedge clk);
        data_bus.req = 1'b1; data_bus.wr = 1'b1; data_bus.wstrb = 4'h3;
        data_bus.addr = 32'h8000_1004; data_bus.wdata = 32'h0000_BEEF;
        #1;
        checks++; if (data_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL wr_d_addr_ok: got %0b want 1", data_bus.addr_ok); end
        @(negedge clk);
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.wstrb = 4'hF; data_bus.wdata = 32'hDEAD_DEAD;
        #1;
        checks++; if (mem_bus.wr !== 1'b1) begin errors++; $display("FAIL wr_m_wr: got %0b want 1", mem_bus.wr); end
        checks++; if (mem_bus.wstrb !== 4'h3) begin errors++; $display("FAIL wr_m_wstrb: got %h want 3", mem_bus.wstrb); end
        checks++; if (mem_bus.wdata !== 32'h0000_BEEF) begin errors++; $display("FAIL wr_m_wdata: got %h want 0000beef", mem_bus.wdata); end
        checks++; if (mem_bus.addr !== 32'h8000_1004) begin errors++; $display("FAIL wr_m_addr: got %h want 80001004", mem_bus.addr); end
        @(negedge clk);
        mem_bus.addr_ok = 1'b1;
        #1;
        checks++; if (mem_bus.wstrb !== 4'h3) begin errors++; $display("FAIL wr_m_wstrb_held: got %h want 3", mem_bus.wstrb); end
        checks++; if (mem_bus.wdata !== 32'h0000_BEEF) begin errors++; $display("FAIL wr_m_wdata_held: got %h want 0000beef", mem_bus.wdata); end
        @(negedge clk);
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0;
        #1;
        checks++; if (data_bus.data_ok !== 1'b1) begin errors++; $display("FAIL wr_d_data_ok: got %0b want 1", data_bus.data_ok); end
        checks++; if (inst_bus.data_ok !== 1'b0) begin errors++; $display("FAIL wr_i_data_ok: got %0b want 0", inst_bus.data_ok); end
        @(negedge clk);
        mem_bus.data_ok = 1'b0;
        #1;
        checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL wr_d_data_ok_pulse: got %0b want 0", data_bus.data_ok); end
    endtask

    task automatic test_stall();
        @(negedge clk);
        data_bus.req = 1'b1; data_bus.wr = 1'b0; data_bus.wstrb = 4'h0; data_bus.addr = 32'h8000_2000;
        #1;
        checks++; if (data_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL stall_d_addr_ok: got %0b want 1", data_bus.addr_ok); end
        @(negedge clk);
        data_bus.req = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) data_bus.addr = 32'h1234_5678;
            // A response pulse during REQ must be ignored.
            mem_bus.data_ok = (c == 3);
            #1;
            checks++; if (mem_bus.req !== 1'b1) begin errors++; $display("FAIL stall_m_req[%0d]: got %0b want 1", c, mem_bus.req); end
            checks++; if (mem_bus.addr !== 32'h8000_2000) begin errors++; $display("FAIL stall_m_addr[%0d]: got %h want 80002000", c, mem_bus.addr); end
            checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL stall_d_data_ok[%0d]: got %0b want 0", c, data_bus.data_ok); end
            @(negedge clk);
        end
        mem_bus.data_ok = 1'b0; mem_bus.addr_ok = 1'b1;
        @(negedge clk);
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'hCAFE_F00D;
        #1;
        checks++; if (data_bus.data_ok !== 1'b1) begin errors++; $display("FAIL stall_d_data_ok: got %0b want 1", data_bus.data_ok); end
        checks++; if (data_bus.rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL stall_d_rdata: got %h want cafef00d", data_bus.rdata); end
        @(negedge clk);
        mem_bus.data_ok = 1'b0;
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0010;
        @(negedge clk);
        inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
        @(negedge clk);
        mem_bus.addr_ok = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h5555_AAAA;
        #1;
        checks++; if (inst_bus.data_ok !== 1'b0) begin errors++; $display("FAIL rst_stale_i_data_ok: got %0b want 0", inst_bus.data_ok); end
        checks++; if (data_bus.data_ok !== 1'b0) begin errors++; $display("FAIL rst_stale_d_data_ok: got %0b want 0", data_bus.data_ok); end
        checks++; if (mem_bus.req !== 1'b0) begin errors++; $display("FAIL rst_m_req: got %0b want 0", mem_bus.req); end
        @(negedge clk);
        mem_bus.data_ok = 1'b0;
        inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0020;
        #1;
        checks++; if (inst_bus.addr_ok !== 1'b1) begin errors++; $display("FAIL rst_i_regrant: got %0b want 1", inst_bus.addr_ok); end
        @(negedge clk);
        inst_bus.req = 1'b0; mem_bus.addr_ok = 1'b1;
        #1;
        checks++; if (mem_bus.addr !== 32'hBFC0_0020) begin errors++; $display("FAIL rst_m_addr: got %h want bfc00020", mem_bus.addr); end
        @(negedge clk);
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'h0BAD_CAFE;
        #1;
        checks++; if (inst_bus.data_ok !== 1'b1) begin errors++; $display("FAIL rst_i_data_ok: got %0b want 1", inst_bus.data_ok); end
        checks++; if (inst_bus.rdata !== 32'h0BAD_CAFE) begin errors++; $display("FAIL rst_i_rdata: got %h want 0badcafe", inst_bus.rdata); end
        @(negedge clk);
        mem_bus.data_ok = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic        exp_data;
        logic [31:0] exp_addr;
        // last grant is inst here, so the order must be D, I, D, I.
        @(negedge clk);
        inst_bus.req = 1'b1; inst_bus.addr = 32'hBFC0_0100;
        data_bus.req = 1'b1; data_bus.wr = 1'b0; data_bus.addr = 32'h8000_0100;
        for (int t = 0; t < 4; t++) begin
            exp_data = (t % 2 == 0);
            exp_addr = exp_data ? 32'h8000_0100 : 32'hBFC0_0100;
            #1;
            checks++; if ({data_bus.addr_ok, inst_bus.addr_ok} !== {exp_data, ~exp_data}) begin errors++; $display("FAIL b2b_grant[%0d]: got d=%0b i=%0b want d=%0b i=%0b", t, data_bus.addr_ok, inst_bus.addr_ok, exp_data, ~exp_data); end
            @(negedge clk);
            mem_bus.addr_ok = 1'b1;
            #1;
            checks++; if (mem_bus.addr !== exp_addr) begin errors++; $display("FAIL b2b_m_addr[%0d]: got %h want %h", t, mem_bus.addr, exp_addr); end
            checks++; if ({data_bus.data_ok, inst_bus.data_ok} !== 2'b00) begin errors++; $display("FAIL b2b_early_data_ok[%0d]: got %b want 00", t, {data_bus.data_ok, inst_bus.data_ok}); end
            @(negedge clk);
            mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b1; mem_bus.rdata = 32'(t);
            #1;
            checks++; if ({data_bus.data_ok, inst_bus.data_ok} !== {exp_data, ~exp_data}) begin errors++; $display("FAIL b2b_data_ok[%0d]: got d=%0b i=%0b want d=%0b i=%0b", t, data_bus.data_ok, inst_bus.data_ok, exp_data, ~exp_data); end
            checks++; if ({data_bus.addr_ok, inst_bus.addr_ok} !== 2'b00) begin errors++; $display("FAIL b2b_grant_in_wait[%0d]: got %b want 00", t, {data_bus.addr_ok, inst_bus.addr_ok}); end
            @(negedge clk);
            mem_bus.data_ok = 1'b0;
        end
        inst_bus.req = 1'b0; data_bus.req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1;
        inst_bus.req = 1'b0; inst_bus.wr = 1'b0; inst_bus.wstrb = 4'h0;
        inst_bus.addr = 32'h0; inst_bus.wdata = 32'h0;
        data_bus.req = 1'b0; data_bus.wr = 1'b0; data_bus.wstrb = 4'h0;
        data_bus.addr = 32'h0; data_bus.wdata = 32'h0;
        mem_bus.addr_ok = 1'b0; mem_bus.data_ok = 1'b0; mem_bus.rdata = 32'h0;

        test_reset();
        test_inst_read();
        test_simultaneous();
        test_data_write();
        test_stall();
        test_reset_in_wait();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
